chart_sequencer: RTL and testbench
==================================

Name: chart_sequencer

Overview:
- Reads the step chart row by row from a synchronous chart ROM.
- Times each row to a fixed number of video frames.
- Issues per-lane launch pulses to the arrow-movement blocks and consumes their next-row acknowledge.
- Sits between the chart memory and the per-lane arrow movement/judging logic, pacing the whole song.

Parameters:
- CHART_DEPTH, 64, number of chart rows in the ROM.
- ADDR_W, 6, ROM address width; must satisfy 2^ADDR_W >= CHART_DEPTH.
- LANES, 4, number of arrow lanes (bits per row mask).
- BEAT_FRAMES, 30, frames per chart row (legal range 1..255).
- ACK_TIMEOUT, 16, clk cycles to wait for next_i after a launch.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous active-high reset.
- frame_i  in  1  one-cycle pulse per video frame.
- start_i  in  1  one-cycle pulse; begins playback from row 0.
- next_i  in  1  acknowledge from the movement blocks; high while any lane is consuming a launch.
- rd_data_i  in  LANES+1  ROM data: [LANES-1:0] is the lane mask, [LANES] is the end-of-chart marker; valid 1 cycle after rd_addr_o.
- rd_addr_o  out  ADDR_W  ROM read address.
- launch_o  out  LANES  per-lane launch pulse, exactly one cycle.
- busy_o  out  1  playback active.
- done_o  out  1  chart finished; held until the next start.
- dropped_o  out  1  sticky error flag: ack timeout or beat overrun.

Behaviour:
- Reset (async, any state):
  - state IDLE; rd_addr_o=0; launch_o=0; busy_o=0; done_o=0; dropped_o=0.
  - beat counter=0; beat_pending=0; row register=0.
- States: IDLE, FETCH, LOAD, TIMING, LAUNCH, ACK, DONE.
- IDLE:
  - start_i -> FETCH; rd_addr_o=0; done_o and dropped_o cleared; beat counter=0.
- FETCH: rd_addr_o is stable for this cycle -> LOAD (1-cycle ROM latency).
- LOAD: latch rd_data_i into the row register -> TIMING.
- Beat counter:
  - Runs only while busy_o=1 (FETCH through ACK); counts frame_i pulses.
  - beat_tick = frame_i AND counter==BEAT_FRAMES-1; the counter then wraps to 0.
  - A beat_tick outside TIMING sets beat_pending.
  - A beat_tick while beat_pending is already 1 sets dropped_o (overrun); beat_pending stays 1.
- TIMING: wait for beat_tick, or consume beat_pending (clearing it). Then:
  - end marker=1 -> DONE; the mask is ignored.
  - mask==0 -> advance (rest row, no launch).
  - mask!=0 -> LAUNCH.
- LAUNCH: launch_o = mask for exactly one cycle; ack timer cleared -> ACK.
- ACK:
  - next_i=1 -> advance.
  - ACK_TIMEOUT cycles without next_i -> set dropped_o, then advance.
  - next_i outside ACK is ignored.
- Advance:
  - rd_addr_o == CHART_DEPTH-1 -> DONE; there is no wrap.
  - Otherwise rd_addr_o+1 -> FETCH.
- DONE:
  - done_o=1; busy_o=0; beat counter frozen.
  - start_i restarts playback exactly as from IDLE.
- busy_o=1 in FETCH, LOAD, TIMING, LAUNCH and ACK.
- start_i while busy_o=1 is ignored.
- launch_o=0 in every state except LAUNCH.
- Reset asserted mid-row: all outputs return to reset values immediately; no residual launch pulse.
- Simultaneous beat_tick and next_i in ACK: the advance is taken and beat_pending is set.

Test Plan:
- BEAT_FRAMES=2; ROM rows {0001, 0100, end}; frame_i every 10 clk; next_i returned 2 cycles after each launch -> launch_o=0001 then 0100, two frames apart; done_o=1 after row 2; dropped_o=0.
- Rest row: ROM {0000, 1000, end} -> no launch on the beat for row 0; launch_o=1000 one beat later; rd_addr_o sequence 0,1,2.
- Ack timeout: next_i held 0, ACK_TIMEOUT=16 -> dropped_o rises exactly 16 cycles after the launch pulse; rd_addr_o increments; playback continues.
- Overrun: BEAT_FRAMES=1; next_i delayed beyond 2 frames -> beat_pending set, then dropped_o=1; the following row launches immediately on entering TIMING.
- No end marker, CHART_DEPTH=4, all rows 0010 -> 4 launches; done_o=1 after address 3; rd_addr_o never returns to 0.
- reset_i pulsed during ACK -> all outputs 0 asynchronously; start_i afterwards -> rd_addr_o=0 and first launch on the first beat.

Source files
------------

// File: rtl/chart_sequencer.sv
// Chart sequencer: walks the step-chart ROM one row per beat, launches the lane
// arrows for each row and waits for the movement blocks to acknowledge them.
module chart_sequencer #(
  parameter int CHART_DEPTH = 64,
  parameter int ADDR_W      = 6,
  parameter int LANES       = 4,
  parameter int BEAT_FRAMES = 30,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              frame_i,
  input  logic              start_i,
  input  logic              next_i,
  input  logic [LANES:0]    rd_data_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [LANES-1:0]  launch_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              dropped_o
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    TIMING,
    LAUNCH,
    ACK,
    DONE
  } state_t;

  localparam int                TMR_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [7:0]        BEAT_LAST = 8'(BEAT_FRAMES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHART_DEPTH - 1);
  localparam logic [TMR_W-1:0]  ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);

  state_t           state;
  logic [7:0]       beat_cnt;
  logic             beat_pending;
  logic [LANES:0]   row;
  logic [TMR_W-1:0] ack_tmr;

  logic beat_tick;
  logic beat_ready;
  logic rest_or_end;
  logic leave_row;
  logic finish;

  // A row leaves either from TIMING (rest/end row) or from ACK (ack or timeout).
  assign beat_tick   = busy_o && frame_i && (beat_cnt == BEAT_LAST);
  assign beat_ready  = beat_tick || beat_pending;
  assign rest_or_end = row[LANES] || (row[LANES-1:0] == '0);
  assign leave_row   = ((state == TIMING) && beat_ready && rest_or_end) ||
                       ((state == ACK) && (next_i || (ack_tmr == ACK_LAST)));
  assign finish      = row[LANES] || (rd_addr_o == LAST_ADDR);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      rd_addr_o    <= '0;
      launch_o     <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      dropped_o    <= 1'b0;
      beat_cnt     <= '0;
      beat_pending <= 1'b0;
      row          <= '0;
      ack_tmr      <= '0;
    end else begin
      launch_o <= '0;

      if (busy_o && frame_i) begin
        beat_cnt <= beat_tick ? 8'd0 : beat_cnt + 8'd1;
      end

      // A beat that arrives while the row is still busy is remembered once; a second one is an overrun.
      if (beat_tick && (state != TIMING)) begin
        if (beat_pending) begin
          dropped_o <= 1'b1;
        end
        beat_pending <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state        <= FETCH;
            rd_addr_o    <= '0;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            dropped_o    <= 1'b0;
            beat_cnt     <= '0;
            beat_pending <= 1'b0;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          row   <= rd_data_i;
          state <= TIMING;
        end
        TIMING: begin
          if (beat_ready) begin
            beat_pending <= beat_pending && beat_tick;
            if (!rest_or_end) begin
              launch_o <= row[LANES-1:0];
              state    <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          ack_tmr <= '0;
          state   <= ACK;
        end
        ACK: begin
          if (!next_i) begin
            if (ack_tmr == ACK_LAST) begin
              dropped_o <= 1'b1;
            end else begin
              ack_tmr <= ack_tmr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // The chart never wraps: the last ROM row or an end marker finishes the song.
      if (leave_row) begin
        if (finish) begin
          state  <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end else begin
          rd_addr_o <= rd_addr_o + 1'b1;
          state     <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_chart_sequencer.sv
// Bench for chart_sequencer: table of whole-chart runs plus hand-written
// sequences for ack timeout, beat overrun and reset in the middle of a row.
module tb_chart_sequencer;

  localparam int FRAME_PERIOD = 10;
  localparam int BEAT_CYC     = 2 * FRAME_PERIOD;
  localparam int ACK_TMO_A    = 16;

  typedef struct {
    logic [3:0][4:0] rom;
    int              n_launch;
    logic [3:0][3:0] masks;
    int              first_frames;
    int              last_addr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i;
  logic       frame_i;
  logic       start_a, start_b;
  logic       next_a, next_b;
  logic [4:0] rd_data_a, rd_data_b;
  logic [1:0] rd_addr_a, rd_addr_b;
  logic [3:0] launch_a, launch_b;
  logic       busy_a, busy_b, done_a, done_b, dropped_a, dropped_b;

  logic [4:0] rom_a [4];
  logic [4:0] rom_b [4];
  logic       ack_en_a;
  int         ack_cd;
  int         frame_div;
  int         cyc = 0;

  int         n_cmp;
  int         n_fail;

  int         nl;
  int         frames_a;
  int         lcyc [8];
  int         lframes [8];
  logic [3:0] lmask [8];
  logic [1:0] prev_addr;
  logic [3:0] prev_launch;
  bit         bad_step;
  bit         long_pulse;

  vec_t vecs [4];

  chart_sequencer #(
    .CHART_DEPTH(4), .ADDR_W(2), .LANES(4), .BEAT_FRAMES(2), .ACK_TIMEOUT(ACK_TMO_A)
  ) dut_a (
    .clk_i(clk), .reset_i(reset_i), .frame_i(frame_i), .start_i(start_a),
    .next_i(next_a), .rd_data_i(rd_data_a), .rd_addr_o(rd_addr_a),
    .launch_o(launch_a), .busy_o(busy_a), .done_o(done_a), .dropped_o(dropped_a)
  );

  chart_sequencer #(
    .CHART_DEPTH(4), .ADDR_W(2), .LANES(4), .BEAT_FRAMES(1), .ACK_TIMEOUT(40)
  ) dut_b (
    .clk_i(clk), .reset_i(reset_i), .frame_i(frame_i), .start_i(start_b),
    .next_i(next_b), .rd_data_i(rd_data_b), .rd_addr_o(rd_addr_b),
    .launch_o(launch_b), .busy_o(busy_b), .done_o(done_b), .dropped_o(dropped_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous chart ROMs with one cycle of read latency.
  always @(posedge clk) begin
    rd_data_a <= rom_a[rd_addr_a];
    rd_data_b <= rom_b[rd_addr_b];
  end

  initial begin
    frame_i   = 1'b0;
    frame_div = 0;
    forever begin
      @(posedge clk); #1;
      if (frame_div == FRAME_PERIOD - 1) begin
        frame_div = 0;
        frame_i   = 1'b1;
      end else begin
        frame_div++;
        frame_i = 1'b0;
      end
    end
  end

  // Movement-block stand-in for dut_a: acknowledges each launch two cycles later.
  initial begin
    next_a = 1'b0;
    ack_cd = 0;
    forever begin
      @(posedge clk); #1;
      next_a = 1'b0;
      if (ack_cd > 0) begin
        ack_cd--;
        if (ack_cd == 0) next_a = 1'b1;
      end
      if (ack_en_a && (launch_a != 4'd0)) ack_cd = 2;
    end
  end

  always @(negedge clk) begin
    if (start_a) begin
      nl          = 0;
      frames_a    = 0;
      prev_addr   = 2'd0;
      prev_launch = 4'd0;
      bad_step    = 1'b0;
      long_pulse  = 1'b0;
    end else begin
      if (busy_a && frame_i) frames_a++;
      if (launch_a != 4'd0) begin
        if (nl < 8) begin
          lmask[nl]   = launch_a;
          lcyc[nl]    = cyc;
          lframes[nl] = frames_a;
        end
        nl++;
      end
      if ((launch_a != 4'd0) && (prev_launch != 4'd0)) long_pulse = 1'b1;
      if (busy_a && (rd_addr_a != prev_addr)) begin
        if (int'(rd_addr_a) != int'(prev_addr) + 1) bad_step = 1'b1;
        prev_addr = rd_addr_a;
      end
      prev_launch = launch_a;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_i = 1'b1;
    @(posedge clk); #1 reset_i = 1'b0;
  endtask

  task automatic start_run_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic start_run_b();
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
  endtask

  task automatic wait_done_a();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_a) break;
    end
    #1;
  endtask

  task automatic pulse_next_b();
    @(posedge clk); #1 next_b = 1'b1;
    @(posedge clk); #1 next_b = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    for (int r = 0; r < 4; r++) rom_a[r] = v.rom[r];
    do_reset();
    start_run_a();
    wait_done_a();
  endtask

  initial begin
    bit found;
    int cnt;

    reset_i  = 1'b1;
    start_a  = 1'b0;
    start_b  = 1'b0;
    next_b   = 1'b0;
    ack_en_a = 1'b1;
    n_cmp    = 0;
    n_fail   = 0;
    for (int r = 0; r < 4; r++) begin
      rom_a[r] = 5'd0;
      rom_b[r] = 5'd0;
    end

    vecs[0].rom = {5'b00000, 5'b10000, 5'b00100, 5'b00001};
    vecs[0].masks = {4'h0, 4'h0, 4'b0100, 4'b0001};
    vecs[0].n_launch = 2; vecs[0].first_frames = 2; vecs[0].last_addr = 2;
    vecs[1].rom = {5'b00000, 5'b10000, 5'b01000, 5'b00000};
    vecs[1].masks = {4'h0, 4'h0, 4'h0, 4'b1000};
    vecs[1].n_launch = 1; vecs[1].first_frames = 4; vecs[1].last_addr = 2;
    vecs[2].rom = {5'b00010, 5'b00010, 5'b00010, 5'b00010};
    vecs[2].masks = {4'b0010, 4'b0010, 4'b0010, 4'b0010};
    vecs[2].n_launch = 4; vecs[2].first_frames = 2; vecs[2].last_addr = 3;
    vecs[3].rom = {5'b00000, 5'b00000, 5'b00000, 5'b11111};
    vecs[3].masks = '0;
    vecs[3].n_launch = 0; vecs[3].first_frames = 0; vecs[3].last_addr = 0;

    repeat (3) @(negedge clk);
    check_output("rst_addr_a", rd_addr_a, 0);
    check_output("rst_launch_a", launch_a, 0);
    check_output("rst_busy_a", busy_a, 0);
    check_output("rst_done_a", done_a, 0);
    check_output("rst_dropped_a", dropped_a, 0);
    check_output("rst_addr_b", rd_addr_b, 0);
    check_output("rst_launch_b", launch_b, 0);
    check_output("rst_busy_b", busy_b, 0);
    check_output("rst_done_b", done_b, 0);
    check_output("rst_dropped_b", dropped_b, 0);
    @(posedge clk); #1 reset_i = 1'b0;

    for (int s = 0; s < 4; s++) begin
      apply_stimulus(vecs[s]);
      check_output($sformatf("s%0d_done", s), done_a, 1);
      check_output($sformatf("s%0d_busy", s), busy_a, 0);
      check_output($sformatf("s%0d_dropped", s), dropped_a, 0);
      check_output($sformatf("s%0d_last_addr", s), rd_addr_a, vecs[s].last_addr);
      check_output($sformatf("s%0d_addr_step", s), bad_step, 0);
      check_output($sformatf("s%0d_pulse_width", s), long_pulse, 0);
      check_output($sformatf("s%0d_n_launch", s), nl, vecs[s].n_launch);
      for (int i = 0; i < vecs[s].n_launch; i++) begin
        check_output($sformatf("s%0d_mask%0d", s, i), lmask[i], vecs[s].masks[i]);
        if (i == 0)
          check_output($sformatf("s%0d_first_beat", s), lframes[0], vecs[s].first_frames);
        else
          check_output($sformatf("s%0d_gap%0d", s, i), lcyc[i] - lcyc[i-1], BEAT_CYC);
      end
    end

    // Ack timeout: no acknowledge for the first row.
    ack_en_a = 1'b0;
    rom_a[0] = 5'b00001; rom_a[1] = 5'b00010; rom_a[2] = 5'b10000; rom_a[3] = 5'b00000;
    do_reset();
    start_run_a();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (launch_a != 4'd0) begin found = 1'b1; break; end
    end
    check_output("tmo_launch_seen", found, 1);
    repeat (ACK_TMO_A) @(negedge clk);
    check_output("tmo_drop_early", dropped_a, 0);
    @(negedge clk);
    check_output("tmo_drop_set", dropped_a, 1);
    check_output("tmo_addr_step", rd_addr_a, 1);
    ack_en_a = 1'b1;
    wait_done_a();
    check_output("tmo_done", done_a, 1);
    check_output("tmo_n_launch", nl, 2);
    check_output("tmo_mask1", lmask[1], 4'b0010);
    check_output("tmo_drop_sticky", dropped_a, 1);

    // Reset in the middle of a row's acknowledge wait.
    ack_en_a = 1'b0;
    rom_a[0] = 5'b00001; rom_a[1] = 5'b00100; rom_a[2] = 5'b10000; rom_a[3] = 5'b00000;
    do_reset();
    start_run_a();
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dropped_a) begin found = 1'b1; break; end
    end
    check_output("mid_drop_seen", found, 1);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (launch_a != 4'd0) begin found = 1'b1; break; end
    end
    check_output("mid_launch_seen", found, 1);
    @(negedge clk);
    #2 reset_i = 1'b1;
    #1;
    check_output("mid_rst_addr", rd_addr_a, 0);
    check_output("mid_rst_launch", launch_a, 0);
    check_output("mid_rst_busy", busy_a, 0);
    check_output("mid_rst_done", done_a, 0);
    check_output("mid_rst_dropped", dropped_a, 0);
    @(posedge clk); #1 reset_i = 1'b0;
    ack_en_a = 1'b1;
    start_run_a();
    @(negedge clk);
    check_output("mid_restart_addr", rd_addr_a, 0);
    check_output("mid_restart_busy", busy_a, 1);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (launch_a != 4'd0) begin found = 1'b1; break; end
    end
    #1;
    check_output("mid_restart_launch_seen", found, 1);
    check_output("mid_restart_mask", lmask[0], 4'b0001);
    check_output("mid_restart_first_beat", lframes[0], 2);

    // Beat overrun on the one-frame-per-beat instance.
    rom_b[0] = 5'b00001; rom_b[1] = 5'b00100; rom_b[2] = 5'b10000; rom_b[3] = 5'b00000;
    start_run_b();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (launch_b != 4'd0) begin found = 1'b1; break; end
    end
    check_output("ovr_launch0", launch_b, 4'b0001);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (frame_i) break;
    end
    @(negedge clk);
    check_output("ovr_pending_no_drop", dropped_b, 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (frame_i) break;
    end
    @(negedge clk);
    check_output("ovr_drop_set", dropped_b, 1);
    pulse_next_b();
    cnt   = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (launch_b != 4'd0) begin found = 1'b1; break; end
    end
    check_output("ovr_immediate_latency", cnt, 4);
    check_output("ovr_launch1", launch_b, 4'b0100);
    pulse_next_b();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_b) begin found = 1'b1; break; end
    end
    check_output("ovr_done", done_b, 1);
    check_output("ovr_drop_sticky", dropped_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
